r16_wd_dispatch: RTL and testbench
==================================

Name: r16_wd_dispatch

Overview:
- Downstream consumer of the 16-lane, 21-cycle twiddle-word delay line in the DTFAG.
- Captures each 16-word twiddle bundle and tags it with stage/group position.
- Optionally substitutes trivial twiddles (value 1) in the last stage, then presents the bundle to the radix-16 butterfly multiplier stage through a 2-entry valid/ready buffer.
- Sequences one full FFT pass (all stages × groups) per start pulse and flags completion.

Parameters:
- D_WIDTH, 64, width of one twiddle word.
- STAGES, 3, number of radix-16 stages per pass (≥1).
- GROUPS, 16, bundles per stage (≥1, ≤65536).
- TRIVIAL_LAST, 1, 1 = replace all lanes with ONE_VAL in stage STAGES-1; 0 = pass through.
- ONE_VAL, 64'd1, substitution value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass when IDLE.
- wd_in  in  16*D_WIDTH  delayed twiddle lanes; lane j at [j*D_WIDTH +: D_WIDTH].
- wd_in_valid  in  1  wd_in holds a bundle.
- wd_in_ready  out  1  block accepts a bundle this cycle.
- wd_out  out  16*D_WIDTH  dispatched twiddle lanes, same lane packing.
- wd_out_valid  out  1  wd_out valid.
- wd_out_ready  in  1  butterfly stage accepts.
- wd_out_stage  out  16  stage index of the bundle on wd_out.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset: one clock and an asynchronous, active-low reset (rst_n) are fixed.
  - Asserting rst_n low at any time forces state IDLE, empties the FIFO and clears counters.
  - All outputs read 0 while reset is asserted and after release until the first event.
  - A pass in progress is abandoned; no done pulse is issued.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - wd_in_ready=0.
  - start=1 → clear stage_cnt and group_cnt, go to RUN.
  - start is ignored in every other state.
- RUN:
  - wd_in_ready = (fifo_count < 2); no push-through when full.
  - accept = wd_in_valid & wd_in_ready.
  - On accept: push {processed bundle, stage_cnt}. group_cnt increments; at GROUPS-1 it wraps to 0 and stage_cnt increments.
  - Accept of group GROUPS-1 in stage STAGES-1 → DRAIN.
- DRAIN: wd_in_ready=0; when fifo_count==0 → DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in RUN, DRAIN and DONE.
- Processing at accept time:
  - If TRIVIAL_LAST=1 and stage_cnt==STAGES-1, every lane = ONE_VAL[D_WIDTH-1:0].
  - Otherwise lanes are passed through, with rotation as described under Optional Feature.
- FIFO: 2 entries, registered output.
  - wd_out_valid = fifo_count != 0; wd_out and wd_out_stage come from the head.
  - Latency: a bundle accepted at edge N is visible on wd_out after edge N (1 cycle).
  - Push and pop in the same cycle keep the count unchanged and preserve order.
  - While wd_out_valid & !wd_out_ready, wd_out and wd_out_stage hold stable.
  - When the FIFO is empty, wd_out and wd_out_stage hold their last value; they read 0 after reset.
- Counter wrap: stage_cnt and group_cnt never exceed STAGES-1 and GROUPS-1; no overflow paths.
- GROUPS=1: every accept advances the stage.
- STAGES=1: the first stage is also the last, so trivial substitution applies to all bundles.

Optional Feature:
- Macro R16_WD_ROT_EN.
- Defined: output lane j = input lane (j + group_cnt[3:0]) mod 16, using group_cnt at accept time. This aligns twiddles with the butterfly's bank-rotated data. Rotation is applied before trivial substitution, so it has no effect in a substituted stage.
- Undefined: lane j out = lane j in, with no rotation logic.

Test Plan:
- Reset, then STAGES=3, GROUPS=16, wd_out_ready=1, wd_in_valid held 1, lane j = 0x100*stage+j → 48 accepts, outputs in order, stages 0/1 pass through, stage 2 all lanes =1, done pulses once 2 cycles after the last accept, busy falls with it.
- wd_out_ready=0 during RUN → exactly 2 accepts, wd_in_ready=0 afterwards, wd_out stable. Raise ready → resumes with no loss or duplication, order intact.
- start asserted in RUN and in DRAIN → ignored; counters and output sequence unchanged.
- rst_n pulsed low mid-stage-1 (group 5) → outputs 0 immediately, state IDLE, no done. A new start restarts at stage 0, group 0.
- R16_WD_ROT_EN defined, TRIVIAL_LAST=0, group 3 bundle lane j = j → wd_out lane j = (j+3) mod 16. Without the macro, lane j = j.
- STAGES=1, GROUPS=1 → single accept yields all lanes = ONE_VAL, wd_out_stage = 0, done follows.

Source files
------------

// File: rtl/r16_wd_dispatch_if.sv
// Twiddle-bundle handshake between the DTFAG delay line, the dispatcher and the radix-16 butterfly stage.
// The slave modport is the dispatcher's view; master is the surrounding datapath.
interface r16_wd_dispatch_if #(
  parameter int D_WIDTH = 64
);
  logic [16*D_WIDTH-1:0] wd_in;
  logic                  wd_in_valid;
  logic                  wd_in_ready;
  logic [16*D_WIDTH-1:0] wd_out;
  logic                  wd_out_valid;
  logic                  wd_out_ready;
  logic [15:0]           wd_out_stage;

  modport master (
    output wd_in, wd_in_valid, wd_out_ready,
    input  wd_in_ready, wd_out, wd_out_valid, wd_out_stage
  );

  modport slave (
    input  wd_in, wd_in_valid, wd_out_ready,
    output wd_in_ready, wd_out, wd_out_valid, wd_out_stage
  );
endinterface

// File: rtl/r16_wd_dispatch.sv
// Radix-16 twiddle dispatcher: tags 16-lane bundles with their stage, optionally forces last-stage twiddles
// to ONE_VAL, and feeds the butterfly stage through a 2-entry buffer. Define R16_WD_ROT_EN for lane rotation.
module r16_wd_dispatch #(
  parameter int                 D_WIDTH      = 64,
  parameter int                 STAGES       = 3,
  parameter int                 GROUPS       = 16,
  parameter int                 TRIVIAL_LAST = 1,
  parameter logic [D_WIDTH-1:0] ONE_VAL      = D_WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  r16_wd_dispatch_if.slave bus,
  output logic             busy,
  output logic             done
);
  localparam int          LW         = 16 * D_WIDTH;
  localparam logic [15:0] LAST_STAGE = 16'(STAGES - 1);
  localparam logic [15:0] LAST_GROUP = 16'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [15:0]   stage_cnt;
  logic [15:0]   group_cnt;
  logic [1:0]    fifo_count;
  logic [LW-1:0] head_data;
  logic [LW-1:0] tail_data;
  logic [15:0]   head_stage;
  logic [15:0]   tail_stage;
  logic [LW-1:0] rotated;
  logic [LW-1:0] processed;
  logic          accept;
  logic          pop;

  assign bus.wd_in_ready  = (state == RUN) && (fifo_count != 2'd2);
  assign accept           = bus.wd_in_valid && bus.wd_in_ready;
  assign pop              = (fifo_count != 2'd0) && bus.wd_out_ready;
  assign bus.wd_out_valid = (fifo_count != 2'd0);
  assign bus.wd_out       = head_data;
  assign bus.wd_out_stage = head_stage;

  // Rotation happens first, so a substituted stage ignores it entirely.
  always_comb begin
    // NOTE: each always_comb target gets a default on entry so no path can infer a latch.
    rotated = bus.wd_in;
`ifdef R16_WD_ROT_EN
    for (int j = 0; j < 16; j++) begin
      rotated[j*D_WIDTH +: D_WIDTH] =
        bus.wd_in[((j + int'(group_cnt[3:0])) % 16) * D_WIDTH +: D_WIDTH];
    end
`endif
    processed = rotated;
    if (TRIVIAL_LAST != 0 && stage_cnt == LAST_STAGE) begin
      for (int j = 0; j < 16; j++) begin
        processed[j*D_WIDTH +: D_WIDTH] = ONE_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage_cnt <= '0;
      group_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register here samples pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            stage_cnt <= '0;
            group_cnt <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (group_cnt == LAST_GROUP) begin
              group_cnt <= '0;
              if (stage_cnt == LAST_STAGE) begin
                stage_cnt <= '0;
                state     <= DRAIN;
              end else begin
                stage_cnt <= stage_cnt + 16'd1;
              end
            end else begin
              group_cnt <= group_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (fifo_count == 2'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head register is the output itself; it only moves on push-into-empty, push+pop, or refill from tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: buffer storage is reset because wd_out must read 0 until the first bundle arrives.
      fifo_count <= 2'd0;
      head_data  <= '0;
      head_stage <= '0;
      tail_data  <= '0;
      tail_stage <= '0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            head_data  <= processed;
            head_stage <= stage_cnt;
          end else begin
            tail_data  <= processed;
            tail_stage <= stage_cnt;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          if (fifo_count == 2'd2) begin
            head_data  <= tail_data;
            head_stage <= tail_stage;
          end
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          head_data  <= processed;
          head_stage <= stage_cnt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_r16_wd_dispatch.sv
// Scoreboard bench for r16_wd_dispatch: a 3x16 pass instance, a 1x1 trivial instance and a
// 1x4 pass-through instance; expectations follow R16_WD_ROT_EN when it is defined.
module tb_r16_wd_dispatch;
  localparam int DW       = 64;
  localparam int LW       = 16 * DW;
  localparam int PASS_LEN = 48;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [15:0]   stage;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, busy_a, done_a;
  logic start_b, busy_b, done_b;
  logic start_c, busy_c, done_c;

  always #5 clk = ~clk;

  r16_wd_dispatch_if #(.D_WIDTH(DW)) bus_a ();
  r16_wd_dispatch_if #(.D_WIDTH(DW)) bus_b ();
  r16_wd_dispatch_if #(.D_WIDTH(DW)) bus_c ();

  r16_wd_dispatch #(.D_WIDTH(DW), .STAGES(3), .GROUPS(16), .TRIVIAL_LAST(1), .ONE_VAL(64'd1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a), .busy(busy_a), .done(done_a));
  r16_wd_dispatch #(.D_WIDTH(DW), .STAGES(1), .GROUPS(1), .TRIVIAL_LAST(1), .ONE_VAL(64'd1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b), .busy(busy_b), .done(done_b));
  r16_wd_dispatch #(.D_WIDTH(DW), .STAGES(1), .GROUPS(4), .TRIVIAL_LAST(0), .ONE_VAL(64'd1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bus(bus_c), .busy(busy_c), .done(done_c));

  int   errors = 0;
  int   checks = 0;
  exp_t sb_a[$];
  exp_t sb_s[$];
  int   k_a, total_a, cyc_a, last_acc_a, done_cyc_a, done_seen_a;
  logic done_busy_a;

  // Bundle k of a 3x16 pass: lane j = 0x100*stage + j.
  function automatic logic [LW-1:0] bundle_a(input int k);
    logic [LW-1:0] d;
    for (int j = 0; j < 16; j++) d[j*DW +: DW] = DW'(256 * (k / 16) + j);
    return d;
  endfunction

  function automatic exp_t exp_a(input int k);
    exp_t e;
    int   stg, src;
    stg = k / 16;
    for (int j = 0; j < 16; j++) begin
      src = j;
`ifdef R16_WD_ROT_EN
      src = (j + k % 16) % 16;
`endif
      e.data[j*DW +: DW] = (stg == 2) ? DW'(1) : DW'(256 * stg + src);
    end
    e.stage = 16'(stg);
    return e;
  endfunction

  function automatic int bad_lane(input logic [LW-1:0] got, input logic [LW-1:0] want);
    for (int j = 0; j < 16; j++) if (got[j*DW +: DW] !== want[j*DW +: DW]) return j;
    return 0;
  endfunction

  // One clock on dut_a: sample at negedge, then redrive just after the rising edge.
  task automatic step_a();
    exp_t e;
    int   bl;
    @(negedge clk);
    if (bus_a.wd_in_valid && bus_a.wd_in_ready) begin
      sb_a.push_back(exp_a(k_a));
      last_acc_a = cyc_a;
      k_a++;
    end
    if (bus_a.wd_out_valid && bus_a.wd_out_ready) begin
      checks++;
      if (sb_a.size() == 0) begin
        errors++;
        $display("FAIL a_spurious_out: got bundle stage=%0d, want no bundle", bus_a.wd_out_stage);
      end else begin
        e = sb_a.pop_front();
        if (bus_a.wd_out !== e.data || bus_a.wd_out_stage !== e.stage) begin
          errors++;
          bl = bad_lane(bus_a.wd_out, e.data);
          $display("FAIL a_out: lane %0d got %h stage %0d, want %h stage %0d",
                   bl, bus_a.wd_out[bl*DW +: DW], bus_a.wd_out_stage, e.data[bl*DW +: DW], e.stage);
        end
      end
    end
    if (done_a) begin
      done_seen_a++;
      done_cyc_a  = cyc_a;
      done_busy_a = busy_a;
    end
    cyc_a++;
    @(posedge clk);
    #1;
    bus_a.wd_in_valid = (k_a < total_a);
    bus_a.wd_in       = bundle_a(k_a);
  endtask

  task automatic run_pass_a(input bit bp, input bit poke, input string tag);
    exp_t e0;
    bit   poked_run, poked_drain;
    e0 = exp_a(0);
    poked_run = 0;
    poked_drain = 0;
    sb_a.delete();
    k_a = 0; total_a = PASS_LEN; cyc_a = 0; last_acc_a = -1; done_cyc_a = -1;
    done_seen_a = 0; done_busy_a = 1'b0;
    bus_a.wd_out_ready = ~bp;
    bus_a.wd_in_valid  = 1'b1;
    bus_a.wd_in        = bundle_a(0);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    while (done_seen_a == 0 && cyc_a < 400) begin
      step_a();
      start_a = 1'b0;
      if (bp && (cyc_a == 3 || cyc_a == 7)) begin
        checks++;
        if (bus_a.wd_out !== e0.data || bus_a.wd_out_stage !== e0.stage || bus_a.wd_out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s_hold_c%0d: got lane0 %h stage %0d valid %b, want %h stage 0 valid 1",
                   tag, cyc_a, bus_a.wd_out[DW-1:0], bus_a.wd_out_stage, bus_a.wd_out_valid, e0.data[DW-1:0]);
        end
      end
      if (bp && cyc_a == 7) begin
        checks++;
        if (k_a != 2) begin
          errors++;
          $display("FAIL %s_accepts_stalled: got %0d, want 2", tag, k_a);
        end
        checks++;
        if (bus_a.wd_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_ready_full: got %b, want 0", tag, bus_a.wd_in_ready);
        end
        bus_a.wd_out_ready = 1'b1;
      end
      if (poke && !poked_run && k_a == 20) begin
        start_a = 1'b1;
        poked_run = 1;
      end
      if (poke && !poked_drain && k_a == PASS_LEN) begin
        start_a = 1'b1;
        poked_drain = 1;
      end
    end
    start_a = 1'b0;
    checks++;
    if (done_seen_a != 1) begin
      errors++;
      $display("FAIL %s_done_seen: got %0d pulses within budget, want 1", tag, done_seen_a);
    end
    checks++;
    if (k_a != PASS_LEN) begin
      errors++;
      $display("FAIL %s_accepts: got %0d, want %0d", tag, k_a, PASS_LEN);
    end
    checks++;
    if (sb_a.size() != 0) begin
      errors++;
      $display("FAIL %s_undelivered: got %0d bundles left, want 0", tag, sb_a.size());
    end
    checks++;
    if (done_cyc_a - last_acc_a != 3) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d samples after last accept, want 3", tag, done_cyc_a - last_acc_a);
    end
    checks++;
    if (done_busy_a !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_with_done: got %b, want 1", tag, done_busy_a);
    end
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      errors++;
      $display("FAIL %s_after_done: got busy,done=%b%b, want 00", tag, busy_a, done_a);
    end
    if (poke) begin
      repeat (4) step_a();
      checks++;
      if (busy_a !== 1'b0 || done_seen_a != 1) begin
        errors++;
        $display("FAIL %s_start_latched: got busy %b done pulses %0d, want 0 and 1", tag, busy_a, done_seen_a);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.wd_in_ready, bus_a.wd_out_valid, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got ready,valid,busy,done=%b%b%b%b, want 0000",
               bus_a.wd_in_ready, bus_a.wd_out_valid, busy_a, done_a);
    end
    checks++;
    if (bus_a.wd_out !== '0 || bus_a.wd_out_stage !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: got lane0 %h stage %0d, want 0 and 0", bus_a.wd_out[DW-1:0], bus_a.wd_out_stage);
    end
    checks++;
    if ({bus_b.wd_out_valid, busy_b, done_b, bus_c.wd_out_valid, busy_c, done_c} !== 6'b0 ||
        bus_b.wd_out !== '0 || bus_c.wd_out !== '0) begin
      errors++;
      $display("FAIL reset_small: got b valid,busy,done=%b%b%b c=%b%b%b, want all 0",
               bus_b.wd_out_valid, busy_b, done_b, bus_c.wd_out_valid, busy_c, done_c);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.wd_in_ready, bus_a.wd_out_valid, busy_a, done_a} !== 4'b0000 || bus_a.wd_out !== '0) begin
      errors++;
      $display("FAIL post_reset: got ready,valid,busy,done=%b%b%b%b lane0 %h, want 0000 and 0",
               bus_a.wd_in_ready, bus_a.wd_out_valid, busy_a, done_a, bus_a.wd_out[DW-1:0]);
    end
  endtask

  task automatic test_full_pass();
    run_pass_a(1'b0, 1'b0, "pass");
  endtask

  task automatic test_backpressure();
    run_pass_a(1'b1, 1'b0, "bp");
  endtask

  task automatic test_start_ignored();
    run_pass_a(1'b0, 1'b1, "start_ign");
  endtask

  task automatic test_reset_mid();
    sb_a.delete();
    k_a = 0; total_a = PASS_LEN; cyc_a = 0; done_seen_a = 0;
    bus_a.wd_out_ready = 1'b1;
    bus_a.wd_in_valid  = 1'b1;
    bus_a.wd_in        = bundle_a(0);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    while (k_a < 21 && cyc_a < 100) step_a();
    checks++;
    if (k_a != 21) begin
      errors++;
      $display("FAIL mid_accepts: got %0d before reset, want 21", k_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.wd_in_ready, bus_a.wd_out_valid, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_flags: got ready,valid,busy,done=%b%b%b%b, want 0000",
               bus_a.wd_in_ready, bus_a.wd_out_valid, busy_a, done_a);
    end
    checks++;
    if (bus_a.wd_out !== '0 || bus_a.wd_out_stage !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_data: got lane0 %h stage %0d, want 0 and 0", bus_a.wd_out[DW-1:0], bus_a.wd_out_stage);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_a.delete();
    k_a = 0;
    done_seen_a = 0;
    bus_a.wd_in = bundle_a(0);
    repeat (5) step_a();
    checks++;
    if (k_a != 0 || done_seen_a != 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got accepts %0d done pulses %0d busy %b, want 0 0 0", k_a, done_seen_a, busy_a);
    end
    run_pass_a(1'b0, 1'b0, "restart");
  endtask

  task automatic test_trivial_single();
    exp_t          e;
    int            acc, dcnt;
    logic [LW-1:0] d;
    acc = 0;
    dcnt = 0;
    sb_s.delete();
    for (int j = 0; j < 16; j++) d[j*DW +: DW] = DW'(32'hAB00 + j);
    bus_b.wd_in = d;
    bus_b.wd_in_valid  = 1'b1;
    bus_b.wd_out_ready = 1'b1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int c = 0; c < 20 && dcnt == 0; c++) begin
      @(negedge clk);
      if (bus_b.wd_in_valid && bus_b.wd_in_ready) begin
        acc++;
        for (int j = 0; j < 16; j++) e.data[j*DW +: DW] = DW'(1);
        e.stage = 16'd0;
        sb_s.push_back(e);
      end
      if (bus_b.wd_out_valid && bus_b.wd_out_ready) begin
        checks++;
        if (sb_s.size() == 0) begin
          errors++;
          $display("FAIL b_spurious_out: got stage %0d, want no bundle", bus_b.wd_out_stage);
        end else begin
          e = sb_s.pop_front();
          if (bus_b.wd_out !== e.data || bus_b.wd_out_stage !== e.stage) begin
            errors++;
            $display("FAIL b_out: lane %0d got %h stage %0d, want %h stage %0d", bad_lane(bus_b.wd_out, e.data),
                     bus_b.wd_out[bad_lane(bus_b.wd_out, e.data)*DW +: DW], bus_b.wd_out_stage, DW'(1), e.stage);
          end
        end
      end
      if (done_b) dcnt++;
      @(posedge clk);
      #1;
      if (acc > 0) bus_b.wd_in_valid = 1'b0;
    end
    checks++;
    if (acc != 1 || dcnt != 1 || sb_s.size() != 0) begin
      errors++;
      $display("FAIL b_pass: got accepts %0d done %0d left %0d, want 1 1 0", acc, dcnt, sb_s.size());
    end
  endtask

  task automatic test_rotation();
    exp_t          e;
    int            acc, dcnt, src;
    logic [LW-1:0] d;
    acc = 0;
    dcnt = 0;
    sb_s.delete();
    for (int j = 0; j < 16; j++) d[j*DW +: DW] = DW'(j);
    bus_c.wd_in = d;
    bus_c.wd_in_valid  = 1'b1;
    bus_c.wd_out_ready = 1'b1;
    start_c = 1'b1;
    @(posedge clk);
    #1;
    start_c = 1'b0;
    for (int c = 0; c < 30 && dcnt == 0; c++) begin
      @(negedge clk);
      if (bus_c.wd_in_valid && bus_c.wd_in_ready) begin
        for (int j = 0; j < 16; j++) begin
          src = j;
`ifdef R16_WD_ROT_EN
          src = (j + acc) % 16;
`endif
          e.data[j*DW +: DW] = DW'(src);
        end
        e.stage = 16'd0;
        sb_s.push_back(e);
        acc++;
      end
      if (bus_c.wd_out_valid && bus_c.wd_out_ready) begin
        checks++;
        if (sb_s.size() == 0) begin
          errors++;
          $display("FAIL c_spurious_out: got stage %0d, want no bundle", bus_c.wd_out_stage);
        end else begin
          e = sb_s.pop_front();
          if (bus_c.wd_out !== e.data || bus_c.wd_out_stage !== e.stage) begin
            errors++;
            $display("FAIL c_out: lane %0d got %h, want %h", bad_lane(bus_c.wd_out, e.data),
                     bus_c.wd_out[bad_lane(bus_c.wd_out, e.data)*DW +: DW],
                     e.data[bad_lane(bus_c.wd_out, e.data)*DW +: DW]);
          end
        end
      end
      if (done_c) dcnt++;
      @(posedge clk);
      #1;
      if (acc >= 4) bus_c.wd_in_valid = 1'b0;
    end
    checks++;
    if (acc != 4 || dcnt != 1 || sb_s.size() != 0) begin
      errors++;
      $display("FAIL c_pass: got accepts %0d done %0d left %0d, want 4 1 0", acc, dcnt, sb_s.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bus_a.wd_in = '0; bus_a.wd_in_valid = 1'b0; bus_a.wd_out_ready = 1'b0;
    bus_b.wd_in = '0; bus_b.wd_in_valid = 1'b0; bus_b.wd_out_ready = 1'b0;
    bus_c.wd_in = '0; bus_c.wd_in_valid = 1'b0; bus_c.wd_out_ready = 1'b0;
    test_reset();
    test_full_pass();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_trivial_single();
    test_rotation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
